adc_sample_packer: RTL and testbench
====================================

// Module: adc_sample_packer
// PURPOSE
//  Consumes one deserialised ADC word per SmpClkDiv cycle after frame alignment.
//  Sits directly downstream of the frame aligner: its FrmAlignDone drives SmpAlignDone.
//  Converts samples to signed 16 bit, packs two per 32-bit word and frames fixed-length packets.
//  Buffers words in a FIFO toward an AXI-Stream-style sink.
// PARAMETERS
//  AdcBits    14  sample width; legal values 8/10/12/14
//  OffsetBin  1   1 = input is offset-binary: invert MSB to get two's complement; 0 = already signed
//  FifoDepth  16  FIFO entries, power of 2, >= 4
//  PktWords   256 words per packet; >= 2
//  SettleCyc  16  consecutive SmpAlignDone=1 cycles required before capture starts
// PORTS
//  SmpClkDiv    in  1        parallel-word clock, same as frame aligner ClkDiv
//  SmpRst_n     in  1        asynchronous active-low reset; deassertion is synchronous to SmpClkDiv
//  SmpData      in  AdcBits  deserialised sample, valid every cycle
//  SmpAlignDone in  1        frame alignment status
//  SmpEnable    in  1        capture request (level)
//  SmpTdata     out 32       {sample1, sample0}; sample0 = earlier in time, at [15:0]
//  SmpTvalid    out 1        output word valid
//  SmpTlast     out 1        last word of packet
//  SmpTready    in  1        sink accepts word when SmpTvalid & SmpTready
//  SmpOverflow  out 1        sticky: a word was dropped on FIFO full
//  SmpDropCnt   out 16       dropped-word count, saturates at 16'hFFFF
//  SmpBusy      out 1        1 when state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFO empty; all counters 0.
//  Sample conversion: s = OffsetBin ? {~SmpData[MSB], SmpData[MSB-1:0]} : SmpData.
//    Sign-extend s to 16 bits.
//  FSM:
//   IDLE  -> ARM when SmpEnable=1. Entering ARM clears SmpOverflow and SmpDropCnt.
//   ARM   -> settle counter increments while SmpAlignDone=1 and clears to 0 when it is 0.
//            -> RUN on the cycle the counter reaches SettleCyc.
//            -> IDLE if SmpEnable=0.
//   RUN   -> capture one sample every cycle. Pair phase toggles 0/1.
//            Phase 1 forms a word; word counter wc counts 0..PktWords-1.
//            SmpEnable=0: capture continues until the word with wc=PktWords-1 is formed, then -> IDLE.
//            SmpAlignDone=0: -> ABORT immediately. The sample of that cycle is not captured.
//            Any pending half-pair is discarded.
//   ABORT -> if wc != 0, write pad word 32'h0 with last=1. Then -> IDLE. Takes 1 cycle.
//  Simultaneous align loss and enable drop: align loss wins (ABORT).
//  Word write: a word is formed at phase 1; last=(wc==PktWords-1); wc wraps to 0 after last.
//  FIFO:
//   Entry = {last, data}.
//   Capture writes are allowed only when count <= FifoDepth-2; one slot is always reserved for the ABORT pad.
//   A word formed when count > FifoDepth-2 is dropped: SmpOverflow <= 1, SmpDropCnt++ (saturating).
//   wc still advances on a dropped word, so packet boundaries stay time-aligned.
//  Output:
//   Registered, first-word-fall-through.
//   Word formed at cycle N with the FIFO empty -> SmpTvalid=1 at N+1.
//   SmpTdata/SmpTlast stay stable while SmpTvalid & ~SmpTready.
//   Pop and write in the same cycle are allowed at any count.
//  Reset mid-operation clears everything immediately, including FIFO contents.
//  Words still buffered when the FSM returns to IDLE continue to drain to the sink.
// TESTING
//  1. PktWords=4, OffsetBin=1, AdcBits=14, SmpTready=1.
//     Enable, hold AlignDone, feed 14'h2000,14'h2001,...
//     -> after 16 settle cycles, words 32'h0001_0000, 32'h0003_0002, ...; SmpTlast on every 4th word.
//  2. OffsetBin=1: input 14'h0000 -> 16'hE000; 14'h3FFF -> 16'h1FFF.
//     OffsetBin=0: 14'h3FFF -> 16'hFFFF.
//  3. SmpTready=0 for 40 cycles in RUN, FifoDepth=16.
//     -> exactly 15 words buffered; SmpOverflow=1; SmpDropCnt = formed-15.
//     Buffered words are intact on release.
//  4. Drop AlignDone at wc=2 with a half-pair pending (PktWords=4).
//     -> pad 32'h0 with SmpTlast=1 follows word 1; state IDLE; SmpBusy=0 next cycle.
//  5. Drop SmpEnable at wc=1 -> capture continues through wc=3 (SmpTlast), then IDLE.
//     No pad word is written.
//  6. Assert SmpRst_n=0 asynchronously mid-packet.
//     -> all outputs 0 in the same cycle; SmpTvalid stays 0 after release until a new capture.

Source files
------------

// File: rtl/adc_sample_packer.sv
// ADC sample packer: converts aligned ADC samples to signed 16 bit, pairs them into
// 32-bit words, frames fixed-length packets and buffers them toward a stream sink.
module adc_sample_packer #(
    parameter int ADC_BITS   = 14,
    parameter int OFFSET_BIN = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_WORDS  = 256,
    parameter int SETTLE_CYC = 16
) (
    input  logic                i_smp_clk_div,
    input  logic                i_smp_rst_n,
    input  logic [ADC_BITS-1:0] i_smp_data,
    input  logic                i_smp_align_done,
    input  logic                i_smp_enable,
    output logic [31:0]         o_smp_tdata,
    output logic                o_smp_tvalid,
    output logic                o_smp_tlast,
    input  logic                i_smp_tready,
    output logic                o_smp_overflow,
    output logic [15:0]         o_smp_drop_cnt,
    output logic                o_smp_busy
);

    localparam int WC_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [WC_W-1:0]  WC_LAST     = WC_W'(PKT_WORDS - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_WR_MAX  = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    function automatic logic [15:0] f_to_s16(input logic [ADC_BITS-1:0] d);
        logic [ADC_BITS-1:0] s;
        s = d;
        if (OFFSET_BIN != 0) begin
            s[ADC_BITS-1] = ~d[ADC_BITS-1];
        end else begin
            s[ADC_BITS-1] = d[ADC_BITS-1];
        end
        return {{(16-ADC_BITS){s[ADC_BITS-1]}}, s};
    endfunction

    function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ST_W-1:0]   r_settle;
    logic              r_phase;
    logic [15:0]       r_low;
    logic [WC_W-1:0]   r_wc;
    logic              r_stop;
    logic              r_overflow;
    logic [15:0]       r_drop_cnt;
    logic              r_busy;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [32:0]       r_mem [FIFO_DEPTH];
    logic              r_tvalid;
    logic [31:0]       r_tdata;
    logic              r_tlast;

    logic [15:0]       w_s16;
    logic              w_arm_enter;
    logic              w_capture;
    logic              w_form;
    logic              w_last;
    logic              w_pad;
    logic              w_room;
    logic              w_fifo_wr;
    logic              w_drop;
    logic [32:0]       w_wr_entry;
    logic              w_pop;
    logic [CNT_W-1:0]  w_cnt_after_pop;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic              w_head_vld;
    logic [32:0]       w_head;

    assign w_s16 = f_to_s16(i_smp_data);

    // FSM state register
    always_ff @(posedge i_smp_clk_div or negedge i_smp_rst_n) begin
        if (!i_smp_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; align loss in RUN takes priority over a stop request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_smp_enable) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!i_smp_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_smp_align_done && (r_settle == SETTLE_LAST)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_RUN: begin
                if (!i_smp_align_done) begin
                    w_state_nxt = ST_ABORT;
                end else if (r_phase && (r_wc == WC_LAST) && (r_stop || !i_smp_enable)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: capture, word formation and FIFO write selection
    always_comb begin
        w_arm_enter = (r_state == ST_IDLE) && i_smp_enable;
        w_capture   = (r_state == ST_RUN) && i_smp_align_done;
        w_form      = w_capture && r_phase;
        w_last      = (r_wc == WC_LAST);
        w_pad       = (r_state == ST_ABORT) && (r_wc != {WC_W{1'b0}});
        w_room      = (r_count <= CNT_WR_MAX);
        w_fifo_wr   = (w_form && w_room) || w_pad;
        w_drop      = w_form && !w_room;
        if (w_pad) begin
            w_wr_entry = {1'b1, 32'h0000_0000};
        end else begin
            w_wr_entry = {w_last, w_s16, r_low};
        end
    end

    // Settle counter, pair phase, held low half and word counter
    always_ff @(posedge i_smp_clk_div or negedge i_smp_rst_n) begin
        if (!i_smp_rst_n) begin
            r_settle <= {ST_W{1'b0}};
            r_phase  <= 1'b0;
            r_low    <= 16'h0000;
            r_wc     <= {WC_W{1'b0}};
        end else begin
            if (r_state == ST_ARM) begin
                r_settle <= i_smp_align_done ? (r_settle + ST_W'(1)) : {ST_W{1'b0}};
            end else begin
                r_settle <= {ST_W{1'b0}};
            end
            r_phase <= w_capture ? ~r_phase : 1'b0;
            if (w_capture && !r_phase) begin
                r_low <= w_s16;
            end
            // wc advances even on dropped words so packet boundaries stay time-aligned
            if (w_form) begin
                r_wc <= w_last ? {WC_W{1'b0}} : (r_wc + WC_W'(1));
            end else if (r_state != ST_RUN) begin
                r_wc <= {WC_W{1'b0}};
            end
        end
    end

    // Stop request latch, overflow/drop status and busy flag
    always_ff @(posedge i_smp_clk_div or negedge i_smp_rst_n) begin
        if (!i_smp_rst_n) begin
            r_stop     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
            r_busy     <= 1'b0;
        end else begin
            if (r_state != ST_RUN) begin
                r_stop <= 1'b0;
            end else if (!i_smp_enable) begin
                r_stop <= 1'b1;
            end
            if (w_arm_enter) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= 16'h0000;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= f_sat_inc16(r_drop_cnt);
            end
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    // FIFO pop and next-head selection; count includes the word held in the output register
    always_comb begin
        w_pop           = r_tvalid && i_smp_tready;
        w_cnt_after_pop = r_count - CNT_W'(w_pop);
        w_rd_nxt        = r_rd_ptr + PTR_W'(w_pop);
        if (w_cnt_after_pop != {CNT_W{1'b0}}) begin
            w_head_vld = 1'b1;
            w_head     = r_mem[w_rd_nxt];
        end else if (w_fifo_wr) begin
            w_head_vld = 1'b1;
            w_head     = w_wr_entry;
        end else begin
            w_head_vld = 1'b0;
            w_head     = 33'd0;
        end
    end

    // FIFO storage array
    always_ff @(posedge i_smp_clk_div) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // FIFO pointers, occupancy and registered first-word-fall-through output
    always_ff @(posedge i_smp_clk_div or negedge i_smp_rst_n) begin
        if (!i_smp_rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_tvalid <= 1'b0;
            r_tdata  <= 32'h0000_0000;
            r_tlast  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_fifo_wr);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_after_pop + CNT_W'(w_fifo_wr);
            r_tvalid <= w_head_vld;
            r_tdata  <= w_head[31:0];
            r_tlast  <= w_head[32];
        end
    end

    assign o_smp_tdata    = r_tdata;
    assign o_smp_tvalid   = r_tvalid;
    assign o_smp_tlast    = r_tlast;
    assign o_smp_overflow = r_overflow;
    assign o_smp_drop_cnt = r_drop_cnt;
    assign o_smp_busy     = r_busy;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench for adc_sample_packer: a transaction-level model predicts every
// accepted word and the status outputs; a monitor compares words on each handshake.
module tb_adc_sample_packer;

    localparam int ADC   = 14;
    localparam int DEPTH = 16;
    localparam int PKT   = 4;
    localparam int SETTLE = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_ABORT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic al;
    logic rdy;
    logic [13:0] din;

    logic [31:0] tdata0, tdata1;
    logic        tvalid0, tvalid1, tlast0, tlast1, ovf0, ovf1, busy0, busy1;
    logic [15:0] drop0, drop1;

    int errors = 0;
    int checks = 0;

    int  m_mode, m_settle, m_wc, m_fifo_n, m_drops;
    bit  m_ovf, m_stop;
    logic [15:0] pend0[$];
    logic [15:0] pend1[$];
    logic [32:0] exp0[$];
    logic [32:0] exp1[$];

    bit          got_first = 1'b0;
    logic [32:0] first0;
    logic [32:0] e0, e1;

    always #5 clk = ~clk;

    adc_sample_packer #(.ADC_BITS(ADC), .OFFSET_BIN(1), .FIFO_DEPTH(DEPTH),
                        .PKT_WORDS(PKT), .SETTLE_CYC(SETTLE)) dut0 (
        .i_smp_clk_div(clk), .i_smp_rst_n(rst_n), .i_smp_data(din),
        .i_smp_align_done(al), .i_smp_enable(en), .o_smp_tdata(tdata0),
        .o_smp_tvalid(tvalid0), .o_smp_tlast(tlast0), .i_smp_tready(rdy),
        .o_smp_overflow(ovf0), .o_smp_drop_cnt(drop0), .o_smp_busy(busy0));

    adc_sample_packer #(.ADC_BITS(ADC), .OFFSET_BIN(0), .FIFO_DEPTH(DEPTH),
                        .PKT_WORDS(PKT), .SETTLE_CYC(SETTLE)) dut1 (
        .i_smp_clk_div(clk), .i_smp_rst_n(rst_n), .i_smp_data(din),
        .i_smp_align_done(al), .i_smp_enable(en), .o_smp_tdata(tdata1),
        .o_smp_tvalid(tvalid1), .o_smp_tlast(tlast1), .i_smp_tready(rdy),
        .o_smp_overflow(ovf1), .o_smp_drop_cnt(drop1), .o_smp_busy(busy1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Offset-binary subtracts half scale; plain two's complement wraps the top half negative
    function automatic logic [15:0] conv(input logic [13:0] d, input bit ob);
        int v;
        v = int'(d);
        if (ob) v = v - 8192;
        else if (v >= 8192) v = v - 16384;
        return 16'(v);
    endfunction

    function automatic logic [13:0] rdata();
        case ($urandom_range(0, 15))
            0: return 14'h0000;
            1: return 14'h3FFF;
            2: return 14'h2000;
            3: return 14'h1FFF;
            default: return 14'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_settle = 0; m_wc = 0; m_fifo_n = 0; m_drops = 0;
        m_ovf = 1'b0; m_stop = 1'b0;
        pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic model_step(input bit i_en, input bit i_al, input logic [13:0] d, input bit i_rdy);
        bit pop, wr, last;
        pop = (m_fifo_n > 0) && i_rdy;
        wr  = 1'b0;
        case (m_mode)
            M_IDLE: if (i_en) begin
                m_mode = M_ARM; m_settle = 0; m_ovf = 1'b0; m_drops = 0;
            end
            M_ARM: if (!i_en) m_mode = M_IDLE;
            else begin
                m_settle = i_al ? m_settle + 1 : 0;
                if (m_settle == SETTLE) begin
                    m_mode = M_RUN; m_wc = 0; m_stop = 1'b0;
                    pend0.delete(); pend1.delete();
                end
            end
            M_RUN: if (!i_al) m_mode = M_ABORT;
            else begin
                pend0.push_back(conv(d, 1'b1));
                pend1.push_back(conv(d, 1'b0));
                if (!i_en) m_stop = 1'b1;
                if (pend0.size() == 2) begin
                    last = (m_wc == PKT - 1);
                    if (m_fifo_n <= DEPTH - 2) begin
                        exp0.push_back({last, pend0[1], pend0[0]});
                        exp1.push_back({last, pend1[1], pend1[0]});
                        wr = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                    m_wc = (m_wc + 1) % PKT;
                    pend0.delete(); pend1.delete();
                    if (last && m_stop) m_mode = M_IDLE;
                end
            end
            default: begin
                if (m_wc != 0) begin
                    exp0.push_back({1'b1, 32'h0});
                    exp1.push_back({1'b1, 32'h0});
                    wr = 1'b1;
                end
                m_wc = 0; pend0.delete(); pend1.delete();
                m_mode = M_IDLE;
            end
        endcase
        m_fifo_n = m_fifo_n - int'(pop) + int'(wr);
    endtask

    task automatic check_cycle();
        chk("tvalid0", 64'(tvalid0), 64'(m_fifo_n != 0));
        chk("tvalid1", 64'(tvalid1), 64'(m_fifo_n != 0));
        chk("busy", 64'(busy0), 64'(m_mode != M_IDLE));
        chk("overflow", 64'(ovf0), 64'(m_ovf));
        chk("drop_cnt", 64'(drop0), 64'(m_drops));
    endtask

    task automatic step(input bit i_en, input bit i_al, input logic [13:0] d, input bit i_rdy);
        en = i_en; al = i_al; din = d; rdy = i_rdy;
        if (rst_n) model_step(i_en, i_al, d, i_rdy);
        @(posedge clk);
        #2;
        check_cycle();
    endtask

    // Monitor: one expected entry is consumed per handshake on each instance
    always @(negedge clk) begin
        if (rst_n && tvalid0 && rdy) begin
            if (exp0.size() == 0) begin
                chk("word0_unexpected", {31'd0, tlast0, tdata0}, 64'h1_FFFF_FFFF_FFFF);
            end else begin
                e0 = exp0.pop_front();
                chk("word0", {31'd0, tlast0, tdata0}, {31'd0, e0});
                if (!got_first) begin
                    got_first = 1'b1;
                    first0 = {tlast0, tdata0};
                end
            end
        end
        if (rst_n && tvalid1 && rdy) begin
            if (exp1.size() == 0) begin
                chk("word1_unexpected", {31'd0, tlast1, tdata1}, 64'h1_FFFF_FFFF_FFFF);
            end else begin
                e1 = exp1.pop_front();
                chk("word1", {31'd0, tlast1, tdata1}, {31'd0, e1});
            end
        end
    end

    initial begin
        bit ok;
        int run_idx;
        logic [13:0] dv;

        rst_n = 1'b0; en = 1'b0; al = 1'b0; rdy = 1'b0; din = 14'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_cycle();
        chk("reset_tdata", 64'(tdata0), 64'h0);
        chk("reset_tlast", 64'(tlast0), 64'h0);
        rst_n = 1'b1;

        // Incrementing ramp from the first captured sample
        run_idx = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_mode == M_RUN) begin
                dv = 14'(14'h2000 + run_idx);
                run_idx++;
            end else begin
                dv = 14'h2000;
            end
            step(1'b1, 1'b1, dv, 1'b1);
        end
        chk("first_word", {31'd0, first0}, {31'd0, 1'b0, 32'h0001_0000});

        // Conversion extremes as one aligned pair
        for (int i = 0; i < 4 && pend0.size() != 0; i++) step(1'b1, 1'b1, rdata(), 1'b1);
        step(1'b1, 1'b1, 14'h0000, 1'b1);
        step(1'b1, 1'b1, 14'h3FFF, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, rdata(), 1'b1);

        // Sink stall long enough to fill the FIFO and drop words
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, rdata(), 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, rdata(), 1'b1);

        // Align loss at wc=2 with a half-pair pending, enable dropping together
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_RUN && m_wc == 2 && pend0.size() == 1) begin ok = 1'b1; break; end
            step(1'b1, 1'b1, rdata(), 1'b1);
        end
        chk("reach_abort_point", 64'(ok), 64'h1);
        step(1'b0, 1'b0, rdata(), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rdata(), 1'b1);

        // Enable drop at wc=1: packet completes, no pad
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_RUN && m_wc == 1) begin ok = 1'b1; break; end
            step(1'b1, 1'b1, rdata(), 1'b1);
        end
        chk("reach_run_wc1", 64'(ok), 64'h1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, rdata(), 1'b1);
            if (m_mode == M_IDLE) begin ok = 1'b1; break; end
        end
        chk("stop_to_idle", 64'(ok), 64'h1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rdata(), 1'b1);

        // Asynchronous reset mid-packet with words in flight
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_RUN && m_wc == 2) begin ok = 1'b1; break; end
            step(1'b1, 1'b1, rdata(), $urandom_range(0, 1) == 1);
        end
        chk("reach_reset_point", 64'(ok), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tdata", 64'(tdata0), 64'h0);
        chk("arst_tvalid", 64'(tvalid0), 64'h0);
        chk("arst_tvalid1", 64'(tvalid1), 64'h0);
        chk("arst_tlast", 64'(tlast0), 64'h0);
        chk("arst_overflow", 64'(ovf0), 64'h0);
        chk("arst_drop_cnt", 64'(drop0), 64'h0);
        chk("arst_busy", 64'(busy0), 64'h0);
        model_reset();
        step(1'b1, 1'b1, rdata(), 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rdata(), 1'b1);

        // Randomized traffic
        en = 1'b1; al = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit ne, na;
            ne = ($urandom_range(0, 199) == 0) ? ~en : en;
            if (al) na = ($urandom_range(0, 149) != 0);
            else    na = ($urandom_range(0, 3) == 0);
            step(ne, na, rdata(), $urandom_range(0, 9) < 7);
        end

        // Drain
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, rdata(), 1'b1);
        chk("drain_exp0_empty", 64'(exp0.size()), 64'h0);
        chk("drain_exp1_empty", 64'(exp1.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
